// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Module      : snake_pkg
// Description : Shared opcodes, command field positions and FSM state type
//               for the snake draw-command executor.
// Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

    localparam int CMD_WIDTH     = 32;
    localparam int PAYLOAD_WIDTH = 28;

    localparam logic [3:0] OP_DRAW_CELL = 4'h0;
    localparam logic [3:0] OP_FILL_RECT = 4'h1;

    // Field positions (LSB of each field; widths come from the executor parameters)
    localparam int OPC_LSB        = 28;
    localparam int X0_LSB         = 23;
    localparam int Y0_LSB         = 18;
    localparam int CELL_COLOR_LSB = 10;
    localparam int X1_LSB         = 13;
    localparam int Y1_LSB         = 8;
    localparam int FILL_COLOR_LSB = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CELL = 2'd1,
        ST_FILL = 2'd2
    } state_t;

endpackage : snake_pkg
`default_nettype wire

// File: rtl/snake_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : snake_cmd_fifo
// Description : Synchronous FIFO with wrap-bit pointers so full and empty are
//               distinct; pointers wrap modulo DEPTH (any DEPTH >= 1).
// Revision    : 1.0 - initial release
// ============================================================================
module snake_cmd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int             AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]  LAST_IDX = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic             wr_wrap_q, wr_wrap_d, rd_wrap_q, rd_wrap_d;
    logic             do_push, do_pop;

    assign empty   = (wr_idx_q == rd_idx_q) && (wr_wrap_q == rd_wrap_q);
    assign full    = (wr_idx_q == rd_idx_q) && (wr_wrap_q != rd_wrap_q);
    assign dout    = mem_q[rd_idx_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Next-pointer computation; the wrap bit toggles each time an index passes the last slot
    always_comb begin
        wr_idx_d  = wr_idx_q;
        wr_wrap_d = wr_wrap_q;
        rd_idx_d  = rd_idx_q;
        rd_wrap_d = rd_wrap_q;
        if (do_push) begin
            if (wr_idx_q == LAST_IDX) begin
                wr_idx_d  = '0;
                wr_wrap_d = ~wr_wrap_q;
            end else begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
        end
        if (do_pop) begin
            if (rd_idx_q == LAST_IDX) begin
                rd_idx_d  = '0;
                rd_wrap_d = ~rd_wrap_q;
            end else begin
                rd_idx_d = rd_idx_q + 1'b1;
            end
        end
    end

    // Pointer registers; reset empties the FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx_q  <= '0;
            wr_wrap_q <= 1'b0;
            rd_idx_q  <= '0;
            rd_wrap_q <= 1'b0;
        end else begin
            wr_idx_q  <= wr_idx_d;
            wr_wrap_q <= wr_wrap_d;
            rd_idx_q  <= rd_idx_d;
            rd_wrap_q <= rd_wrap_d;
        end
    end

    // Storage needs no reset: contents are only visible while not empty
    always_ff @(posedge clk) begin
        if (do_push && !rst) begin
            mem_q[wr_idx_q] <= din;
        end
    end

endmodule : snake_cmd_fifo
`default_nettype wire

// File: rtl/snake_cmd_exec.sv
`default_nettype none
// ============================================================================
// Module      : snake_cmd_exec
// Description : Buffers draw commands and executes them as tile-memory writes
//               (single cell or raster-order rectangle fill).
// Revision    : 1.0 - initial release
// ============================================================================
module snake_cmd_exec
    import snake_pkg::*;
#(
    parameter int H_LOGIC_WIDTH  = 5,
    parameter int V_LOGIC_WIDTH  = 5,
    parameter int H_LOGIC_MAX    = 31,
    parameter int V_LOGIC_MAX    = 23,
    parameter int COLOR_ID_WIDTH = 8,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   enb,
    input  logic [CMD_WIDTH-1:0]                   cmd,
    input  logic                                   cmd_vld,
    output logic                                   mem_we,
    output logic [V_LOGIC_WIDTH+H_LOGIC_WIDTH-1:0] mem_addr,
    output logic [COLOR_ID_WIDTH-1:0]              mem_wdata,
    output logic                                   busy,
    output logic                                   fifo_ovf,
    output logic                                   cmd_err,
    input  logic                                   err_clr
);

    localparam int                       AW    = V_LOGIC_WIDTH + H_LOGIC_WIDTH;
    localparam logic [H_LOGIC_WIDTH-1:0] H_MAX = H_LOGIC_WIDTH'(H_LOGIC_MAX);
    localparam logic [V_LOGIC_WIDTH-1:0] V_MAX = V_LOGIC_WIDTH'(V_LOGIC_MAX);

    logic                   fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CMD_WIDTH-1:0]   fifo_dout;

    state_t                     state_q, state_d;
    logic [PAYLOAD_WIDTH-1:0]   cmd_q, cmd_d;
    logic [H_LOGIC_WIDTH-1:0]   cur_x_q, cur_x_d;
    logic [V_LOGIC_WIDTH-1:0]   cur_y_q, cur_y_d;
    logic                       mem_we_q, mem_we_d;
    logic [AW-1:0]              mem_addr_q, mem_addr_d;
    logic [COLOR_ID_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic                       fifo_ovf_q, fifo_ovf_d;
    logic                       cmd_err_q, cmd_err_d;
    logic                       err_event, ovf_event;

    logic [3:0]                 head_op;
    logic [H_LOGIC_WIDTH-1:0]   head_x, f_x0, f_x1;
    logic [V_LOGIC_WIDTH-1:0]   head_y, f_y0, f_y1;
    logic [COLOR_ID_WIDTH-1:0]  cell_color, fill_color;
    logic                       cell_ok, fill_ok;

    // A full FIFO drops the command even when a pop frees a slot this cycle
    assign fifo_push = cmd_vld && !rst && !fifo_full;
    assign ovf_event = cmd_vld && !rst && fifo_full;

    snake_cmd_fifo #(
        .WIDTH (CMD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (cmd),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign head_op    = fifo_dout[OPC_LSB +: 4];
    assign head_x     = fifo_dout[X0_LSB +: H_LOGIC_WIDTH];
    assign head_y     = fifo_dout[Y0_LSB +: V_LOGIC_WIDTH];

    // The executing command: cell and fill share the (x0,y0) field positions
    assign f_x0       = cmd_q[X0_LSB +: H_LOGIC_WIDTH];
    assign f_y0       = cmd_q[Y0_LSB +: V_LOGIC_WIDTH];
    assign f_x1       = cmd_q[X1_LSB +: H_LOGIC_WIDTH];
    assign f_y1       = cmd_q[Y1_LSB +: V_LOGIC_WIDTH];
    assign cell_color = cmd_q[CELL_COLOR_LSB +: COLOR_ID_WIDTH];
    assign fill_color = cmd_q[FILL_COLOR_LSB +: COLOR_ID_WIDTH];

    assign cell_ok = (f_x0 <= H_MAX) && (f_y0 <= V_MAX);
    assign fill_ok = (f_x0 <= f_x1) && (f_y0 <= f_y1) && (f_x1 <= H_MAX) && (f_y1 <= V_MAX);

    assign busy      = !fifo_empty || (state_q != ST_IDLE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign fifo_ovf  = fifo_ovf_q;
    assign cmd_err   = cmd_err_q;

    // Next-state: command fetch/decode, range checks, raster walk and sticky flags
    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fifo_pop    = 1'b0;
        err_event   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && enb) begin
                    fifo_pop = 1'b1;
                    cmd_d    = fifo_dout[PAYLOAD_WIDTH-1:0];
                    cur_x_d  = head_x;
                    cur_y_d  = head_y;
                    if (head_op == OP_DRAW_CELL) begin
                        state_d = ST_CELL;
                    end else if (head_op == OP_FILL_RECT) begin
                        state_d = ST_FILL;
                    end else begin
                        err_event = 1'b1;
                    end
                end
            end
            ST_CELL: begin
                state_d = ST_IDLE;
                if (cell_ok) begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {f_y0, f_x0};
                    mem_wdata_d = cell_color;
                end else begin
                    err_event = 1'b1;
                end
            end
            ST_FILL: begin
                if (!fill_ok) begin
                    err_event = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {cur_y_q, cur_x_q};
                    mem_wdata_d = fill_color;
                    if (cur_x_q == f_x1) begin
                        if (cur_y_q == f_y1) begin
                            state_d = ST_IDLE;
                        end else begin
                            cur_x_d = f_x0;
                            cur_y_d = cur_y_q + 1'b1;
                        end
                    end else begin
                        cur_x_d = cur_x_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A set event in the same cycle as err_clr wins
        fifo_ovf_d = ovf_event ? 1'b1 : (err_clr ? 1'b0 : fifo_ovf_q);
        cmd_err_d  = err_event ? 1'b1 : (err_clr ? 1'b0 : cmd_err_q);
    end

    // State and registered outputs; reset aborts any command in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            fifo_ovf_q  <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            fifo_ovf_q  <= fifo_ovf_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

endmodule : snake_cmd_exec
`default_nettype wire

// File: tb/tb_snake_cmd_exec.sv
`default_nettype none
// ============================================================================
// Module      : tb_snake_cmd_exec
// Description : Scenario tasks for snake_cmd_exec; expected writes are queued
//               by a bench-side command model and compared as writes appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snake_cmd_exec;

    logic        clk, rst, enb, cmd_vld, err_clr;
    logic [31:0] cmd;
    logic        mem_we, busy, fifo_ovf, cmd_err;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int wr_count = 0;
    int last_wr_cyc = 0;
    logic [9:0] last_addr = '0;
    logic [17:0] sb [$];

    snake_cmd_exec dut (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .cmd       (cmd),
        .cmd_vld   (cmd_vld),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .fifo_ovf  (fifo_ovf),
        .cmd_err   (cmd_err),
        .err_clr   (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every observed write must match the head of the expected queue
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            logic [17:0] exp_w;
            wr_count++;
            last_wr_cyc = cyc;
            last_addr   = mem_addr;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%h required=no write", mem_addr, mem_wdata);
            end else begin
                exp_w = sb.pop_front();
                if ({mem_addr, mem_wdata} !== exp_w) begin
                    errors++;
                    $display("FAIL write_data addr=%0d data=%h required addr=%0d data=%h",
                             mem_addr, mem_wdata, exp_w[17:8], exp_w[7:0]);
                end
            end
        end
    end

    function automatic logic [31:0] mk_cell(int x, int y, int col);
        return {4'h0, 5'(x), 5'(y), 8'(col), 10'h0};
    endfunction

    function automatic logic [31:0] mk_fill(int x0, int y0, int x1, int y1, int col);
        return {4'h1, 5'(x0), 5'(y0), 5'(x1), 5'(y1), 8'(col)};
    endfunction

    // Command model: queue the writes a command should produce
    task automatic push_expected(input logic [31:0] c);
        int x0, y0, x1, y1;
        x0 = int'(c[27:23]);
        y0 = int'(c[22:18]);
        x1 = int'(c[17:13]);
        y1 = int'(c[12:8]);
        if (c[31:28] == 4'h0) begin
            if (x0 <= 31 && y0 <= 23) sb.push_back({5'(y0), 5'(x0), c[17:10]});
        end else if (c[31:28] == 4'h1) begin
            if (x0 <= x1 && y0 <= y1 && x1 <= 31 && y1 <= 23)
                for (int y = y0; y <= y1; y++)
                    for (int x = x0; x <= x1; x++)
                        sb.push_back({5'(y), 5'(x), c[7:0]});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] c);
        cmd     = c;
        cmd_vld = 1'b1;
        tick();
        cmd_vld = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            sample();
            if (!busy && !mem_we) done = 1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout busy=%b required=0 within %0d cycles", name, busy, budget);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_missing_writes pending=%0d required=0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd = mk_cell(1, 1, 8'h11); cmd_vld = 1'b1;
        tick(); tick();
        cmd_vld = 1'b0;
        rst = 1'b0;
        sample();
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs we=%b addr=%0d data=%h required 0/0/0", mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if ({busy, fifo_ovf, cmd_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_status busy/ovf/err=%b%b%b required 000", busy, fifo_ovf, cmd_err);
        end
    endtask

    task automatic test_draw_cell();
        int n_edge, w0;
        logic [31:0] c;
        c = mk_cell(3, 5, 8'h3C);
        w0 = wr_count;
        push_expected(c);
        tick();
        n_edge = cyc + 1;
        send(c);
        wait_idle("draw_cell", 20);
        checks++;
        if (wr_count - w0 != 1) begin
            errors++;
            $display("FAIL draw_cell_count writes=%0d required=1", wr_count - w0);
        end
        checks++;
        if (last_wr_cyc != n_edge + 2) begin
            errors++;
            $display("FAIL draw_cell_latency write_after_edge=%0d required=%0d", last_wr_cyc, n_edge + 2);
        end
        checks++;
        if (last_addr !== 10'd163) begin
            errors++;
            $display("FAIL draw_cell_addr addr=%0d required=163", last_addr);
        end
    endtask

    task automatic test_full_fill();
        logic [31:0] c;
        int seen = 0, first_c = -1, last_c = -1;
        bit done = 0;
        c = mk_fill(0, 0, 31, 23, 8'hFF);
        push_expected(c);
        send(c);
        for (int i = 0; i < 2000 && !done; i++) begin
            sample();
            if (mem_we) begin
                seen++;
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
                if (mem_addr == 10'd767) done = 1;
            end
        end
        checks++;
        if (!done || seen != 768) begin
            errors++;
            $display("FAIL fill_count writes=%0d last_addr_seen=%b required 768 ending at 767", seen, done);
        end
        checks++;
        if (last_c - first_c != 767) begin
            errors++;
            $display("FAIL fill_consecutive span=%0d required=767", last_c - first_c);
        end
        sample();
        checks++;
        if (busy !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL fill_busy_after busy=%b we=%b required 0/0", busy, mem_we);
        end
        wait_idle("full_fill", 10);
    endtask

    task automatic test_fill_then_cell();
        int w0;
        logic [31:0] f, d;
        f = mk_fill(2, 2, 3, 3, 8'h5A);
        d = mk_cell(7, 1, 8'hA5);
        w0 = wr_count;
        push_expected(f);
        push_expected(d);
        send(f);
        send(d);
        wait_idle("fill_then_cell", 40);
        checks++;
        if (wr_count - w0 != 5 || last_addr !== 10'd39) begin
            errors++;
            $display("FAIL fill_then_cell writes=%0d last=%0d required 5 ending at 39", wr_count - w0, last_addr);
        end
    endtask

    task automatic test_back_to_back();
        int w0;
        logic [31:0] c;
        w0  = wr_count;
        enb = 1'b0;
        for (int i = 0; i < 5; i++) begin
            c = mk_cell(i + 10, 20, 8'h40 + i);
            if (i < 4) push_expected(c);
            err_clr = (i == 4);
            send(c);
        end
        err_clr = 1'b0;
        repeat (5) sample();
        checks++;
        if (fifo_ovf !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL overflow_flag ovf=%b busy=%b required 1/1", fifo_ovf, busy);
        end
        checks++;
        if (wr_count != w0) begin
            errors++;
            $display("FAIL enb_hold writes=%0d required=0", wr_count - w0);
        end
        enb = 1'b1;
        wait_idle("back_to_back", 40);
        checks++;
        if (wr_count - w0 != 4) begin
            errors++;
            $display("FAIL back_to_back_count writes=%0d required=4", wr_count - w0);
        end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        sample();
        checks++;
        if (fifo_ovf !== 1'b0) begin
            errors++;
            $display("FAIL overflow_clear ovf=%b required=0", fifo_ovf);
        end
    endtask

    task automatic test_bad_cmds();
        logic [31:0] bad [3];
        int w0;
        bad[0] = {4'h7, 28'h0123456};
        bad[1] = mk_cell(1, 24, 8'h77);
        bad[2] = mk_fill(5, 0, 4, 2, 8'h33);
        w0 = wr_count;
        for (int i = 0; i < 3; i++) begin
            err_clr = 1'b1; tick(); err_clr = 1'b0;
            send(bad[i]);
            wait_idle("bad_cmd", 20);
            checks++;
            if (cmd_err !== 1'b1) begin
                errors++;
                $display("FAIL bad_cmd_%0d cmd_err=%b required=1", i, cmd_err);
            end
        end
        checks++;
        if (wr_count != w0) begin
            errors++;
            $display("FAIL bad_cmd_writes writes=%0d required=0", wr_count - w0);
        end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        sample();
        checks++;
        if (cmd_err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear cmd_err=%b required=0", cmd_err);
        end
    endtask

    task automatic test_reset_mid_fill();
        int seen = 0, w0;
        send({4'hF, 28'h0});
        wait_idle("pre_reset", 20);
        w0 = wr_count;
        for (int i = 0; i < 10; i++) sb.push_back({10'(i), 8'hC3});
        send(mk_fill(0, 0, 31, 23, 8'hC3));
        for (int i = 0; i < 100 && seen < 10; i++) begin
            sample();
            if (mem_we) seen++;
        end
        rst = 1'b1;
        tick();
        checks++;
        if ({mem_we, busy, fifo_ovf, cmd_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_fill we/busy/ovf/err=%b%b%b%b required 0000", mem_we, busy, fifo_ovf, cmd_err);
        end
        rst = 1'b0;
        repeat (40) sample();
        checks++;
        if (wr_count - w0 != 10 || sb.size() != 0) begin
            errors++;
            $display("FAIL reset_mid_fill_writes writes=%0d pending=%0d required 10/0", wr_count - w0, sb.size());
        end
    endtask

    initial begin
        rst = 1'b1; enb = 1'b1; cmd = '0; cmd_vld = 1'b0; err_clr = 1'b0;
        test_reset();
        test_draw_cell();
        test_full_fill();
        test_fill_then_cell();
        test_back_to_back();
        test_bad_cmds();
        test_reset_mid_fill();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_snake_cmd_exec
`default_nettype wire
